// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of a single memory port.
// Define ARB_ROUND_ROBIN_EN to resolve ties round-robin; default is D-cache priority.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ic_read,
  input  logic [27:0]  ic_addr,
  output logic [127:0] ic_rdata,
  output logic         ic_ready,
  input  logic         dc_read,
  input  logic         dc_write,
  input  logic [27:0]  dc_addr,
  input  logic [127:0] dc_wdata,
  output logic [127:0] dc_rdata,
  output logic         dc_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [1:0] {IDLE, GRANT_IC, GRANT_DC, DONE} state_t;

  state_t       state;
  logic [127:0] resp_buf;
  logic         ic_req;
  logic         dc_req;
  logic         grant_dc;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_ic;
`endif

  assign ic_rdata = resp_buf;
  assign dc_rdata = resp_buf;

  always_comb begin
    ic_req = ic_read;
    dc_req = dc_read | dc_write;
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the requester that was not granted last wins.
    grant_dc = dc_req & (~ic_req | last_ic);
`else
    grant_dc = dc_req;
`endif
  end

  // mem_addr/mem_wdata double as the latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      resp_buf  <= '0;
      ic_ready  <= 1'b0;
      dc_ready  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_ic   <= 1'b1;
`endif
    end else begin
      ic_ready <= 1'b0;
      dc_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dc) begin
            state     <= GRANT_DC;
            mem_addr  <= dc_addr;
            mem_wdata <= dc_wdata;
            mem_write <= dc_write;
            mem_read  <= ~dc_write;
`ifdef ARB_ROUND_ROBIN_EN
            last_ic   <= 1'b0;
`endif
          end else if (ic_req) begin
            state     <= GRANT_IC;
            mem_addr  <= ic_addr;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_ic   <= 1'b1;
`endif
          end
        end
        GRANT_IC, GRANT_DC: begin
          if (mem_ready) begin
            resp_buf  <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ic_ready  <= (state == GRANT_IC);
            dc_ready  <= (state == GRANT_DC);
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
